// File: rtl/mem_req_buffer_pkg.sv
// mem_req_buffer_pkg: shared widths, idle address and FSM states for the request buffer
package mem_req_buffer_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int IDLE_ADDR_D = 8191;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/mem_req_buffer_fifo.sv
// mem_req_buffer_fifo: DEPTH-entry request FIFO exposing the head combinationally
module mem_req_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 46,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/mem_req_buffer.sv
// mem_req_buffer: queues engine requests, retries the head at the bank scheduler, returns read data
module mem_req_buffer
  import mem_req_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH = 4,
  parameter int READ_LAT = 1,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR = ADDR_WIDTH'(IDLE_ADDR_D),
  parameter int STARVE_LIM = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_we,
  output logic [ADDR_WIDTH-1:0] sch_addr,
  output logic [DATA_WIDTH-1:0] sch_data,
  output logic                  sch_we,
  input  logic                  sch_grant,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [15:0]           stall_cnt,
  output logic                  starve
);
  localparam int W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(STARVE_LIM + 1);
  logic [CW-1:0] count, count_n;
  logic [W-1:0] head;
  logic head_we, head_valid, push, pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [WW-1:0] wait_cnt;
  logic [READ_LAT-1:0] pipe_v;
  logic [ADDR_WIDTH-1:0] pipe_a [READ_LAT];
  state_t state, state_n;
  mem_req_buffer_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data({req_we, req_addr, req_data}),
    .pop(pop),
    .head(head),
    .count(count)
  );
  assign {head_we, head_addr, head_data} = head;
  assign head_valid = count != '0;
  // ready looks only at the registered count so sch_grant never reaches req_ready
  assign req_ready = count < CW'(DEPTH);
  assign push = req_valid && req_ready;
  assign pop = head_valid && sch_grant;
  assign count_n = count + CW'(push) - CW'(pop);
  assign sch_addr = head_valid ? head_addr : IDLE_ADDR;
  assign sch_data = head_valid ? head_data : '0;
  assign sch_we = head_valid && head_we;
  always_comb begin
    state_n = (count_n == '0) ? IDLE : (head_valid && !sch_grant) ? WAIT : ISSUE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      wait_cnt <= '0;
      starve <= 1'b0;
    end else if (head_valid && !sch_grant) begin
      stall_cnt <= sat_inc16(stall_cnt);
      wait_cnt <= (wait_cnt == WW'(STARVE_LIM)) ? wait_cnt : wait_cnt + 1'b1;
      starve <= starve || (wait_cnt == WW'(STARVE_LIM - 1));
    end else begin
      wait_cnt <= '0;
      starve <= 1'b0;
    end
  // granted reads ride a READ_LAT-deep tag pipe; its tail marks the cycle mem_rdata is valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_a[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_addr <= '0;
      rsp_data <= '0;
    end else begin
      pipe_v[0] <= pop && !head_we;
      pipe_a[0] <= head_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      rsp_valid <= pipe_v[READ_LAT-1];
      if (pipe_v[READ_LAT-1]) begin
        rsp_addr <= pipe_a[READ_LAT-1];
        rsp_data <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_mem_req_buffer.sv
// tb_mem_req_buffer: directed scoreboard bench for mem_req_buffer with a one-cycle bank model
module tb_mem_req_buffer;
  import mem_req_buffer_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, sch_we, sch_grant = 1'b0, rsp_valid, starve;
  logic [12:0] req_addr = '0, sch_addr, rsp_addr;
  logic [31:0] req_data = '0, sch_data, mem_rdata, rsp_data;
  logic [15:0] stall_cnt;
  logic bv = 1'b0;
  logic [12:0] ba = '0;
  logic [44:0] sb [$];
  int errors = 0, checks = 0, rsp_seen = 0, base, exp_stall;

  mem_req_buffer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_we(req_we),
    .sch_addr(sch_addr), .sch_data(sch_data), .sch_we(sch_we),
    .sch_grant(sch_grant), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .stall_cnt(stall_cnt), .starve(starve)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [12:0] a);
    return (a == 13'd5) ? 32'h0000CAFE : (32'hB000_0000 | 32'(a));
  endfunction

  // bank: a granted read returns its word one cycle after the grant cycle
  always @(posedge clk) begin
    bv <= sch_grant && !sch_we && sch_addr != 13'h1FFF;
    ba <= sch_addr;
  end
  assign mem_rdata = bv ? f(ba) : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && rsp_valid) begin
      rsp_seen++;
      chk("rsp_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [44:0] e;
        e = sb.pop_front();
        chk("rsp_addr", 32'(rsp_addr), 32'(e[44:32]));
        chk("rsp_data", rsp_data, e[31:0]);
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [12:0] a, input logic w, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr = a;
    req_we = w;
    req_data = d;
    if (!w) sb.push_back({a, f(a)});
    tick;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sb.delete();
    tick;
    rst = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_sch_addr", 32'(sch_addr), 32'd8191);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_sch_we", 32'(sch_we), 32'd0);
    chk("rst_sch_data", sch_data, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    rst = 1'b0;
    tick;
    // fill with grant held low
    for (int i = 0; i < 4; i++) begin
      push(13'(10 + i), 1'b0, 32'h0);
      chk("fill_stall", 32'(stall_cnt), 32'(i));
    end
    chk("fill_ready", 32'(req_ready), 32'd0);
    chk("fill_head", 32'(sch_addr), 32'd10);
    for (int i = 0; i < 60; i++) tick;
    chk("starve_63", 32'(starve), 32'd0);
    chk("stall_63", 32'(stall_cnt), 32'd63);
    req_valid = 1'b1;
    req_addr = 13'd99;
    tick;
    chk("starve_64", 32'(starve), 32'd1);
    chk("stall_64", 32'(stall_cnt), 32'd64);
    req_valid = 1'b0;
    chk("full_head_kept", 32'(sch_addr), 32'd10);
    sch_grant = 1'b1;
    #1;
    chk("full_pop_ready", 32'(req_ready), 32'd0);
    tick;
    chk("starve_clr", 32'(starve), 32'd0);
    chk("next_head", 32'(sch_addr), 32'd11);
    for (int i = 0; i < 3; i++) tick;
    sch_grant = 1'b0;
    chk("empty_idle", 32'(sch_addr), 32'd8191);
    drain;
    // read latency
    push(13'd5, 1'b0, 32'h0);
    sch_grant = 1'b1;
    tick;
    sch_grant = 1'b0;
    chk("lat_t1", 32'(rsp_valid), 32'd0);
    tick;
    chk("lat_t2", 32'(rsp_valid), 32'd1);
    chk("lat_addr", 32'(rsp_addr), 32'd5);
    chk("lat_data", rsp_data, 32'h0000CAFE);
    tick;
    chk("lat_pulse", 32'(rsp_valid), 32'd0);
    // streaming with grant held, alternating write/read
    base = rsp_seen;
    sch_grant = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_addr = 13'(i);
      req_we = (i % 2 == 0);
      req_data = 32'(i * 7);
      if (i % 2 == 1) sb.push_back({13'(i), f(13'(i))});
      tick;
      chk("stream_head", 32'(sch_addr), 32'(i));
      chk("stream_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    req_we = 1'b0;
    tick;
    sch_grant = 1'b0;
    drain;
    tick;
    chk("stream_rsp_count", 32'(rsp_seen - base), 32'd8);
    // reset with 3 queued entries and a read in flight
    for (int i = 0; i < 4; i++) push(13'(40 + i), 1'b0, 32'h0);
    sch_grant = 1'b1;
    tick;
    sch_grant = 1'b0;
    do_reset;
    chk("mid_rst_addr", 32'(sch_addr), 32'd8191);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    // conflict retry: grant pattern 0,0,1 per entry
    exp_stall = 0;
    for (int i = 0; i < 3; i++) begin
      push(13'(20 + i), 1'b0, 32'h0);
      exp_stall = i;
    end
    chk("retry_stall0", 32'(stall_cnt), 32'(exp_stall));
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("retry_wait", 32'(dut.state), 32'(WAIT));
      tick;
      chk("retry_hold", 32'(sch_addr), 32'(20 + i));
      sch_grant = 1'b1;
      tick;
      sch_grant = 1'b0;
      exp_stall += 2;
      chk("retry_stall", 32'(stall_cnt), 32'(exp_stall));
    end
    drain;
    // saturation
    push(13'd77, 1'b1, 32'h1234);
    for (int i = 0; i < 70000; i++) tick;
    chk("sat_stall", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat_starve", 32'(starve), 32'd1);
    sch_grant = 1'b1;
    tick;
    sch_grant = 1'b0;
    chk("sat_empty", 32'(sch_addr), 32'd8191);
    chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
